// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential RV32I/M ALU: operation encodings, FSM states
// and operation-class helpers.
package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SUB    = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLL    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_SLT    = 5'b01000,
    OP_SLTU   = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_mul(input alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// One-bit-per-cycle engine: unsigned shift-add multiply or restoring divide.
// Divider datapath present only with ALU_SEQ_MD_DIV_EN defined.
module alu_seq_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,    // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] acc
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic               busy_q, busy_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, step_nxt;
`ifdef ALU_SEQ_MD_DIV_EN
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_nxt;
`endif

  always_comb begin
    // Multiply: low half holds the unconsumed multiplier, high half the partial sum.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_SEQ_MD_DIV_EN
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opb_q};
    div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
    step_nxt = mode_q ? div_nxt : mul_nxt;
`else
    step_nxt = mode_q ? acc_q : mul_nxt;
`endif
  end

  always_comb begin
    busy_d = busy_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    if (start) begin
      busy_d = 1'b1;
      mode_d = mode;
      cnt_d  = '0;
      opb_d  = op_b;
      acc_d  = {{WIDTH{1'b0}}, op_a};
    end else if (busy_q) begin
      acc_d = step_nxt;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) busy_d = 1'b0;
    end
  end

  // done flags the final step; acc then already carries its result.
  assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign acc  = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      opb_q  <= opb_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq_md.sv
// Handshaked sequential RV32I/M ALU: 1-cycle base ops, iterative M ops.
// Define ALU_SEQ_MD_DIV_EN to include DIV/DIVU/REM/REMU; otherwise they return 0.
module alu_seq_md
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             LessS,
  output logic             LessU
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               less_s_q, less_s_d, less_u_q, less_u_d;
  logic               neg_q, neg_d, upper_q, upper_d;
  alu_op_e            op;
  logic               accept, sign_a, sign_b, less_s, less_u;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   mag_a, mag_b, base_res, fin;
  logic [2*WIDTH-1:0] prod;
  logic               iter_start, iter_mode, iter_done;
  logic [2*WIDTH-1:0] iter_acc;
`ifdef ALU_SEQ_MD_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] half;
  logic             div_ovf;
`endif

  assign op       = alu_op_e'(ALUControl);
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign shamt    = SrcB[SH_W-1:0];
  assign less_s   = $signed(SrcA) < $signed(SrcB);
  assign less_u   = SrcA < SrcB;
  assign sign_a   = SrcA[WIDTH-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sign_b   = SrcB[WIDTH-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
  assign mag_a    = sign_a ? -SrcA : SrcA;
  assign mag_b    = sign_b ? -SrcB : SrcB;

  always_comb begin
    case (op)
      OP_AND:  base_res = SrcA & SrcB;
      OP_OR:   base_res = SrcA | SrcB;
      OP_ADD:  base_res = SrcA + SrcB;
      OP_SUB:  base_res = SrcA - SrcB;
      OP_XOR:  base_res = SrcA ^ SrcB;
      OP_SLL:  base_res = SrcA << shamt;
      OP_SRL:  base_res = SrcA >> shamt;
      OP_SRA:  base_res = $unsigned($signed(SrcA) >>> shamt);
      OP_SLT:  base_res = WIDTH'(less_s);
      OP_SLTU: base_res = WIDTH'(less_u);
      default: base_res = '0;
    endcase
  end

  // Multiply sign fix applies to the full product; divide fixes the selected half.
  always_comb begin
    prod = neg_q ? -iter_acc : iter_acc;
    fin  = upper_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`ifdef ALU_SEQ_MD_DIV_EN
    half = upper_q ? iter_acc[2*WIDTH-1:WIDTH] : iter_acc[WIDTH-1:0];
    if (state_q == DIV) fin = neg_q ? -half : half;
    div_ovf = (op inside {OP_DIV, OP_REM}) && (SrcA == MOST_NEG) && (SrcB == '1);
`endif
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    less_s_d   = less_s_q;
    less_u_d   = less_u_q;
    neg_d      = neg_q;
    upper_d    = upper_q;
    iter_start = 1'b0;
    iter_mode  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        less_s_d = less_s;
        less_u_d = less_u;
        neg_d    = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
        upper_d  = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
        state_d  = DONE;
        if (is_mul(op)) begin
          iter_start = 1'b1;
          state_d    = MUL;
        end
`ifdef ALU_SEQ_MD_DIV_EN
        else if (is_div(op)) begin
          if (SrcB == '0)   result_d = upper_d ? SrcA : '1;
          else if (div_ovf) result_d = upper_d ? '0 : SrcA;
          else begin
            iter_start = 1'b1;
            iter_mode  = 1'b1;
            state_d    = DIV;
          end
        end
`endif
        else result_d = base_res;
      end
      MUL, DIV: if (iter_done) begin
        result_d = fin;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      less_s_q <= 1'b0;
      less_u_q <= 1'b0;
      neg_q    <= 1'b0;
      upper_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      less_s_q <= less_s_d;
      less_u_q <= less_u_d;
      neg_q    <= neg_d;
      upper_q  <= upper_d;
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (iter_start),
    .mode  (iter_mode),
    .op_a  (mag_a),
    .op_b  (mag_b),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  assign out_valid = (state_q == DONE);
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);
  assign LessS     = less_s_q;
  assign LessU     = less_u_q;

endmodule

// File: tb/tb_alu_seq_md.sv
// Directed self-checking bench for alu_seq_md (WIDTH=32); DIV expectations follow ALU_SEQ_MD_DIV_EN.
module tb_alu_seq_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         Zero, LessS, LessU;
  logic [W-1:0] SrcA, SrcB, ALUResult;
  logic [4:0]   ALUControl;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .Zero(Zero), .LessS(LessS), .LessU(LessU)
  );

  // Issue one op; lat = 1 when out_valid is visible right after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (ALUResult !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", ALUResult); end
    n_checks++; if ({Zero, LessS, LessU} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {Zero, LessS, LessU}); end
    @(negedge clk); reset = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
    n_checks++; if (ALUResult !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result got %h want 80000000", ALUResult); end
    n_checks++; if ({Zero, LessS, LessU} !== 3'b000) begin n_fail++; $display("FAIL add_flags got %b want 000", {Zero, LessS, LessU}); end
    consume();
  endtask

  task automatic test_base();
    logic [4:0]   ops [11] = '{5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                               5'b00111, 5'b01000, 5'b01001, 5'b11111, 5'b01010};
    logic [W-1:0] as  [11] = '{32'hF0F0_F0F0, 32'h0F00_0000, 32'd3, 32'hFFFF_0000, 32'd1, 32'h8000_0000,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
    logic [W-1:0] bs  [11] = '{32'h0FF0_0FF0, 32'h0000_00F0, 32'd3, 32'h0F0F_0F0F, 32'd33, 32'd4,
                               32'd4, 32'd1, 32'd1, 32'd5, 32'd9};
    logic [W-1:0] exp [11] = '{32'h00F0_00F0, 32'h0F00_00F0, 32'd0, 32'hF0F0_0F0F, 32'd2, 32'h0800_0000,
                               32'hF800_0000, 32'd1, 32'd0, 32'd0, 32'd0};
    int lat;
    for (int i = 0; i < 11; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL base_latency[%0d] got %0d want 1", i, lat); end
      n_checks++; if (ALUResult !== exp[i]) begin n_fail++; $display("FAIL base_result[%0d] got %h want %h", i, ALUResult, exp[i]); end
      n_checks++; if (Zero !== (exp[i] == '0)) begin n_fail++; $display("FAIL base_zero[%0d] got %b want %b", i, Zero, exp[i] == '0); end
      consume();
    end
  endtask

  task automatic test_mul();
    logic [4:0]   ops [3] = '{5'b10001, 5'b10011, 5'b10000};
    logic [W-1:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6};
    logic [W-1:0] bs  [3] = '{32'd2, 32'd2, 32'd7};
    logic [W-1:0] exp [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd42};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat); end
      n_checks++; if (ALUResult !== exp[i]) begin n_fail++; $display("FAIL mul_result[%0d] got %h want %h", i, ALUResult, exp[i]); end
      consume();
    end
  endtask

  task automatic test_div();
`ifdef ALU_SEQ_MD_DIV_EN
    logic [4:0]   ops [4] = '{5'b10100, 5'b10110, 5'b10101, 5'b10100};
    logic [W-1:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [W-1:0] bs  [4] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [W-1:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    int           lats[4] = '{33, 33, 1, 1};
    int           n = 4;
`else
    logic [4:0]   ops [2] = '{5'b10100, 5'b10110};
    logic [W-1:0] as  [2] = '{32'd10, 32'd10};
    logic [W-1:0] bs  [2] = '{32'd2, 32'd3};
    logic [W-1:0] exp [2] = '{32'd0, 32'd0};
    int           lats[2] = '{1, 1};
    int           n = 2;
`endif
    int lat;
    for (int i = 0; i < n; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, lats[i]); end
      n_checks++; if (ALUResult !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d] got %h want %h", i, ALUResult, exp[i]); end
      consume();
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(5'b00011, 32'd1, 32'd5, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hold_latency got %0d want 1", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); ALUControl = 5'b00010; SrcA = 32'd9; SrcB = 32'd9;
      #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_hs[%0d] got ov=%b ir=%b want ov=1 ir=0", i, out_valid, in_ready); end
      n_checks++; if (ALUResult !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL hold_result[%0d] got %h want fffffffc", i, ALUResult); end
      n_checks++; if ({Zero, LessS, LessU} !== 3'b011) begin n_fail++; $display("FAIL hold_flags[%0d] got %b want 011", i, {Zero, LessS, LessU}); end
    end
    @(negedge clk); in_valid = 1'b0;
    consume();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    @(negedge clk);
    ALUControl = 5'b10000; SrcA = 32'd6; SrcB = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || ALUResult !== 32'h0) begin n_fail++; $display("FAIL midreset_out got ov=%b res=%h want ov=0 res=0", out_valid, ALUResult); end
    @(negedge clk); reset = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_abort got %0d valid cycles want 0", seen); end
    issue(5'b00011, 32'd3, 32'd3, lat);
    n_checks++; if (lat !== 1 || Zero !== 1'b1) begin n_fail++; $display("FAIL midreset_sub got lat=%0d zero=%b want lat=1 zero=1", lat, Zero); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(5'b00010, 32'd100, 32'd23, lat);
    n_checks++; if (ALUResult !== 32'd123) begin n_fail++; $display("FAIL b2b_first got %h want 0000007b", ALUResult); end
    consume();
    issue(5'b00001, 32'h0000_0F00, 32'h0000_000F, lat);
    n_checks++; if (lat !== 1 || ALUResult !== 32'h0000_0F0F) begin n_fail++; $display("FAIL b2b_second got lat=%0d res=%h want lat=1 res=00000f0f", lat, ALUResult); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_base();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_md.md
# alu_seq_md

Parametrised, handshaked successor to the single-cycle RV32I ALU: executes the base integer operations and the RV32M multiply/divide/remainder group on WIDTH-bit operands. Base operations complete in one cycle; M operations run on an iterative one-bit-per-cycle datapath. Sits in the multi-cycle / pipelined core's execute stage, between operand select and writeback, with valid/ready handshakes on both sides so the datapath stalls while a long operation is in flight.

## Interface
- WIDTH, 32: operand/result width; power of two, 8..64
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- SrcA, SrcB  in  WIDTH  operands, sampled on accept
- ALUControl  in  5  operation select (encodings below)
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes result
- ALUResult  out  WIDTH  result
- Zero  out  1  ALUResult == 0
- LessS, LessU  out  1  signed / unsigned SrcA < SrcB of the accepted operands

## Operation
- Accept = in_valid & in_ready; captures SrcA, SrcB, ALUControl.
- Base ops (1-cycle): 00000 AND, 00001 OR, 00010 ADD, 00011 SUB, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT, 01001 SLTU. Shift amount = SrcB[$clog2(WIDTH)-1:0]; ADD/SUB wrap modulo 2^WIDTH.
- M ops: 10000 MUL (low half), 10001 MULH (s×s high), 10010 MULHSU (s×u high), 10011 MULHU (u×u high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other encoding: 1-cycle, ALUResult = 0.
- Multiply: magnitudes of the signed operands into an unsigned 2·WIDTH shift-add; product negated at finish if the operand signs differ.
- Divide: restoring, on magnitudes; quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Fast-path divide cases (1 cycle, no iteration): divisor 0 → quotient all-ones, remainder = SrcA; signed overflow (A = most-negative, B = −1) → quotient = A, remainder 0.
- FSM: IDLE → (accept base / illegal / fast-path) → DONE; IDLE → (accept mul) → MUL; IDLE → (accept div) → DIV; MUL/DIV → DONE when the counter reaches WIDTH; DONE → IDLE on out_ready.
- Flags: Zero derived from the registered ALUResult; LessS/LessU registered at accept; all held stable in DONE.
- Reset at any time aborts: state IDLE, counter 0, out_valid 0, ALUResult 0, Zero 1, LessS 0, LessU 0; in_ready 1 from the cycle after reset deasserts.

## Timing
- Accept at edge N:
  - base / illegal / fast-path ops: out_valid at N+1
  - MUL/DIV ops: WIDTH iteration cycles, then out_valid at N+WIDTH+1 (33 for WIDTH=32)
- out_valid, ALUResult and flags are held until out_ready. out_ready while out_valid is low has no effect.
- in_ready is low from accept until the DONE→IDLE edge, so the peak rate is one op every 2 cycles.
- in_valid asserted during busy states is ignored; the requester holds it until it sees in_ready.

## Configuration
- ALU_SEQ_MD_DIV_EN defined:
  - divider datapath and DIV state are present
  - 10100–10111 behave as above
- ALU_SEQ_MD_DIV_EN undefined:
  - no divider logic
  - 10100–10111 complete in 1 cycle with ALUResult = 0, the same as illegal encodings
  - multiply is unaffected

## Structure
- alu_seq_pkg holds:
  - alu_op_e: 5-bit enum of all encodings
  - state_e: IDLE, MUL, DIV, DONE
  - helper functions is_mul(op), is_div(op)
- One sub-module, alu_seq_iter: the shared shift-add / restoring-subtract engine. It has start and done signals, a mode input (mul/div), and returns a 2·WIDTH accumulator. The top level keeps the FSM, handshakes, sign correction and base ops.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1: in_ready=1 before the op; out_valid one cycle after accept; ALUResult 0x80000000, Zero 0, LessS 0.
- MULH 0xFFFFFFFF × 0x00000002: out_valid exactly 33 cycles after accept; ALUResult 0xFFFFFFFF. Repeat as MULHU: 0x00000001.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000/−1 → 0x80000000 in 1 cycle.
- Hold out_ready=0 for 5 cycles after out_valid: result and flags stable; in_ready stays 0; in_valid pulses are ignored.
- Assert reset mid-MUL (cycle 10): next cycle out_valid 0, ALUResult 0, in_ready 1; a subsequent SUB 3−3 gives Zero 1.
- Build without ALU_SEQ_MD_DIV_EN: DIV 10/2 → ALUResult 0 after 1 cycle; MUL 6×7 → 42 after 33 cycles.
